// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for a combinational ALU: issues one command at a time,
// holds the ALU inputs for SETTLE cycles, captures the result and hands it back.
module alu_cmd_sequencer #(
    parameter int W      = 16,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_use_acc,
    output logic [4:0]   alu_op,
    output logic [W-1:0] alu_operandA,
    output logic [W-1:0] alu_operandB,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic [W-1:0] acc,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [3:0]   settle_q, settle_d;
    logic [4:0]   alu_op_q, alu_op_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic [W-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic [W-1:0] acc_q, acc_d;
    logic [15:0]  op_count_q, op_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            alu_op_q     <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            acc_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            alu_op_q     <= alu_op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            acc_q        <= acc_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        alu_op_d     = alu_op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        acc_d        = acc_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Operand A chains from the accumulator as it stood before this command.
                    alu_op_d = cmd_op;
                    opa_d    = cmd_use_acc ? acc_q : cmd_a;
                    opb_d    = cmd_b;
                    settle_d = SETTLE_LOAD;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (settle_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                acc_d        = alu_result;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_op       = alu_op_q;
    assign alu_operandA = opa_q;
    assign alu_operandB = opb_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign acc          = acc_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance on a behavioural ALU (SETTLE=1),
// one on a slow stub ALU (SETTLE=3) for settle timing and async reset.
module tb_alu_cmd_sequencer;

    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rst1_n, c1_valid, c1_ready, c1_use, r1_valid, r1_ready;
    logic [4:0]  c1_op, o1_op;
    logic [15:0] c1_a, c1_b, o1_a, o1_b, a1_res, r1_res, acc1, cnt1;
    logic [3:0]  a1_flg, r1_flg;

    logic        rst3_n, c3_valid, c3_ready, c3_use, r3_valid, r3_ready;
    logic [4:0]  c3_op, o3_op;
    logic [15:0] c3_a, c3_b, o3_a, o3_b, a3_res, r3_res, acc3, cnt3;
    logic [3:0]  a3_flg, r3_flg;

    // Reference ALU: a handful of ops, anything else passes B; flags {N,Z,P,0}.
    function automatic logic [19:0] alu_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = b;
        endcase
        return {r[15], (r == 16'h0), ^r, 1'b0, r};
    endfunction

    assign {a1_flg, a1_res} = alu_ref(o1_op, o1_a, o1_b);

    // Stub ALU: output is valid only from the 3rd cycle after its inputs change.
    logic [36:0] st_last = '0;
    logic [2:0]  st_cnt  = 3'd7;
    always @(posedge clk) begin
        if ({o3_op, o3_a, o3_b} != st_last) begin
            st_last <= {o3_op, o3_a, o3_b};
            st_cnt  <= 3'd1;
        end else if (st_cnt != 3'd7) begin
            st_cnt <= st_cnt + 3'd1;
        end
    end
    assign a3_res = (st_cnt >= 3'd3) ? 16'h1234 : 16'h0000;
    assign a3_flg = (st_cnt >= 3'd3) ? 4'b1010 : 4'b0000;

    alu_cmd_sequencer #(.W(16), .SETTLE(1)) u_d1 (
        .clk(clk), .rst_n(rst1_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op), .cmd_a(c1_a),
        .cmd_b(c1_b), .cmd_use_acc(c1_use),
        .alu_op(o1_op), .alu_operandA(o1_a), .alu_operandB(o1_b),
        .alu_result(a1_res), .alu_flags(a1_flg),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_res), .rsp_flags(r1_flg),
        .acc(acc1), .op_count(cnt1)
    );

    alu_cmd_sequencer #(.W(16), .SETTLE(3)) u_d3 (
        .clk(clk), .rst_n(rst3_n),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op), .cmd_a(c3_a),
        .cmd_b(c3_b), .cmd_use_acc(c3_use),
        .alu_op(o3_op), .alu_operandA(o3_a), .alu_operandB(o3_b),
        .alu_result(a3_res), .alu_flags(a3_flg),
        .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_result(r3_res), .rsp_flags(r3_flg),
        .acc(acc3), .op_count(cnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the SETTLE=1 instance; lat = edges from accept to rsp_valid.
    task automatic run1(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic use_acc, input int hold, input bit noise,
                        output logic [15:0] res, output logic [3:0] flg, output int lat,
                        output logic [15:0] opa);
        int k;
        c1_op = op; c1_a = a; c1_b = b; c1_use = use_acc; c1_valid = 1'b1;
        k = 0;
        while (!c1_ready && k < 50) begin tick(); k++; end
        if (!c1_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout d1: cmd_ready=%b required 1", c1_ready);
        end
        tick();
        c1_valid = 1'b0;
        opa = o1_a;
        lat = 0;
        while (!r1_valid && lat < 50) begin
            if (noise) begin
                c1_valid = 1'($urandom); c1_op = 5'($urandom); c1_a = 16'($urandom);
                c1_b = 16'($urandom); c1_use = 1'($urandom);
            end
            tick();
            lat++;
        end
        if (!r1_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout d1: rsp_valid=%b required 1", r1_valid);
        end
        repeat (hold) tick();
        res = r1_res; flg = r1_flg;
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        c1_valid = 1'b0;
    endtask

    task automatic run3(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [3:0] flg, output int lat);
        int k;
        c3_op = op; c3_a = a; c3_b = b; c3_use = 1'b0; c3_valid = 1'b1;
        k = 0;
        while (!c3_ready && k < 50) begin tick(); k++; end
        tick();
        c3_valid = 1'b0;
        lat = 0;
        while (!r3_valid && lat < 50) begin tick(); lat++; end
        if (!r3_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout d3: rsp_valid=%b required 1", r3_valid);
        end
        res = r3_res; flg = r3_flg;
        r3_ready = 1'b1;
        tick();
        r3_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (c1_ready !== 1'b1 || r1_valid !== 1'b0 || o1_op !== 5'd0 || o1_a !== 16'd0 || o1_b !== 16'd0 ||
            r1_res !== 16'd0 || r1_flg !== 4'd0 || acc1 !== 16'd0 || cnt1 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_d1: ready=%b valid=%b op=%h a=%h b=%h res=%h flg=%h acc=%h cnt=%h required 1 0 all-zero",
                     c1_ready, r1_valid, o1_op, o1_a, o1_b, r1_res, r1_flg, acc1, cnt1);
        end
        n_cmp++;
        if (c3_ready !== 1'b1 || r3_valid !== 1'b0 || acc3 !== 16'd0 || cnt3 !== 16'd0 || o3_op !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_d3: ready=%b valid=%b acc=%h cnt=%h op=%h required 1 0 0 0 0",
                     c3_ready, r3_valid, acc3, cnt3, o3_op);
        end
        $display("txn reset checked");
    endtask

    task automatic test_and_direct();
        logic [15:0] va [5] = '{16'hFFE0, 16'hFFF3, 16'd9, 16'd16, 16'd16};
        logic [15:0] vb [5] = '{16'd5, 16'hFFFD, 16'd0, 16'd11, 16'hFFF6};
        logic [15:0] ve [5] = '{16'd0, 16'hFFF1, 16'd0, 16'd0, 16'd16};
        logic [15:0] res, opa;
        logic [3:0]  flg;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run1(OP_AND, va[i], vb[i], 1'b0, 0, 1'b0, res, flg, lat, opa);
            $display("txn and_direct %0d a=%h b=%h res=%h lat=%0d", i, va[i], vb[i], res, lat);
            n_cmp++;
            if (res !== ve[i] || flg !== alu_ref(OP_AND, va[i], vb[i])[19:16]) begin
                n_bad++;
                $display("FAIL and_result_%0d: got %h/%b required %h/%b", i, res, flg, ve[i],
                         alu_ref(OP_AND, va[i], vb[i])[19:16]);
            end
            n_cmp++;
            if (lat !== 2) begin
                n_bad++;
                $display("FAIL and_latency_%0d: got %0d required 2", i, lat);
            end
        end
        n_cmp++;
        if (cnt1 !== 16'd5) begin
            n_bad++;
            $display("FAIL and_op_count: got %0d required 5", cnt1);
        end
    endtask

    task automatic test_acc_chain();
        logic [15:0] res, opa;
        logic [3:0]  flg;
        int lat;
        run1(OP_AND, 16'hFFFF, 16'h00F3, 1'b0, 0, 1'b0, res, flg, lat, opa);
        run1(OP_AND, 16'h7777, 16'hFFFD, 1'b1, 0, 1'b0, res, flg, lat, opa);
        $display("txn acc_chain opa=%h res=%h acc=%h", opa, res, acc1);
        n_cmp++;
        if (opa !== 16'h00F3 || res !== 16'h00F1 || acc1 !== 16'h00F1 || cnt1 !== 16'd7) begin
            n_bad++;
            $display("FAIL acc_chain: opa=%h res=%h acc=%h cnt=%0d required 00f3 00f1 00f1 7", opa, res, acc1, cnt1);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] f1, f2;
        int k;
        f1 = alu_ref(OP_OR, 16'h0F00, 16'h00F0)[19:16];
        f2 = alu_ref(OP_XOR, 16'h5555, 16'hAAAA)[19:16];
        c1_op = OP_OR; c1_a = 16'h0F00; c1_b = 16'h00F0; c1_use = 1'b0; c1_valid = 1'b1;
        k = 0;
        while (!c1_ready && k < 50) begin tick(); k++; end
        tick();
        c1_op = OP_XOR; c1_a = 16'h5555; c1_b = 16'hAAAA;
        k = 0;
        while (!r1_valid && k < 50) begin tick(); k++; end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (r1_valid !== 1'b1 || r1_res !== 16'h0FF0 || r1_flg !== f1 || c1_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: valid=%b res=%h flg=%b ready=%b required 1 0ff0 %b 0",
                         i, r1_valid, r1_res, r1_flg, c1_ready, f1);
            end
            tick();
        end
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        n_cmp++;
        if (c1_ready !== 1'b1 || o1_b !== 16'h00F0 || cnt1 !== 16'd8) begin
            n_bad++;
            $display("FAIL bp_no_early_accept: ready=%b opb=%h cnt=%0d required 1 00f0 8", c1_ready, o1_b, cnt1);
        end
        tick();
        c1_valid = 1'b0;
        n_cmp++;
        if (c1_ready !== 1'b0 || o1_a !== 16'h5555 || o1_b !== 16'hAAAA || o1_op !== OP_XOR) begin
            n_bad++;
            $display("FAIL bp_second_accept: ready=%b op=%h a=%h b=%h required 0 0c 5555 aaaa", c1_ready, o1_op, o1_a, o1_b);
        end
        k = 0;
        while (!r1_valid && k < 50) begin tick(); k++; end
        n_cmp++;
        if (r1_valid !== 1'b1 || r1_res !== 16'hFFFF || r1_flg !== f2) begin
            n_bad++;
            $display("FAIL bp_second_result: valid=%b res=%h flg=%b required 1 ffff %b", r1_valid, r1_res, r1_flg, f2);
        end
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        $display("txn backpressure done cnt=%0d", cnt1);
    endtask

    task automatic test_settle();
        logic [15:0] res;
        logic [3:0]  flg;
        int lat;
        run3(5'h03, 16'h1111, 16'h2222, res, flg, lat);
        $display("txn settle res=%h flg=%b lat=%0d", res, flg, lat);
        n_cmp++;
        if (res !== 16'h1234 || flg !== 4'b1010 || acc3 !== 16'h1234 || cnt3 !== 16'd1) begin
            n_bad++;
            $display("FAIL settle_capture: res=%h flg=%b acc=%h cnt=%0d required 1234 1010 1234 1", res, flg, acc3, cnt3);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL settle_latency: got %0d required 4", lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        logic [3:0]  flg;
        int lat, k;
        c3_op = 5'h03; c3_a = 16'h1112; c3_b = 16'h2222; c3_use = 1'b0; c3_valid = 1'b1;
        k = 0;
        while (!c3_ready && k < 50) begin tick(); k++; end
        tick();
        c3_valid = 1'b0;
        #2 rst3_n = 1'b0;
        #1;
        n_cmp++;
        if (r3_valid !== 1'b0 || acc3 !== 16'd0 || cnt3 !== 16'd0 || c3_ready !== 1'b1 ||
            o3_op !== 5'd0 || o3_a !== 16'd0 || o3_b !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_in_issue: valid=%b acc=%h cnt=%0d ready=%b op=%h a=%h b=%h required 0 0 0 1 0 0 0",
                     r3_valid, acc3, cnt3, c3_ready, o3_op, o3_a, o3_b);
        end
        tick();
        rst3_n = 1'b1;
        c3_a = 16'h1113; c3_valid = 1'b1;
        tick();
        c3_valid = 1'b0;
        k = 0;
        while (!r3_valid && k < 50) begin tick(); k++; end
        #2 rst3_n = 1'b0;
        #1;
        n_cmp++;
        if (r3_valid !== 1'b0 || acc3 !== 16'd0 || cnt3 !== 16'd0 || c3_ready !== 1'b1 ||
            r3_res !== 16'd0 || r3_flg !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_in_resp: valid=%b acc=%h cnt=%0d ready=%b res=%h flg=%b required 0 0 0 1 0 0",
                     r3_valid, acc3, cnt3, c3_ready, r3_res, r3_flg);
        end
        tick();
        rst3_n = 1'b1;
        tick();
        run3(5'h03, 16'h1114, 16'h2222, res, flg, lat);
        $display("txn reset_recovery res=%h lat=%0d cnt=%0d", res, lat, cnt3);
        n_cmp++;
        if (res !== 16'h1234 || flg !== 4'b1010 || lat !== 4 || cnt3 !== 16'd1) begin
            n_bad++;
            $display("FAIL reset_recovery: res=%h flg=%b lat=%0d cnt=%0d required 1234 1010 4 1", res, flg, lat, cnt3);
        end
    endtask

    task automatic test_random();
        logic [15:0] acc_m, cnt_m, a, b, res, opa, expa;
        logic [19:0] exp;
        logic [4:0]  op;
        logic [3:0]  flg;
        logic        use_acc;
        int lat;
        rst1_n = 1'b0;
        #2 rst1_n = 1'b1;
        tick();
        acc_m = 16'd0;
        cnt_m = 16'd0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 6)
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_OR;
                4: op = OP_XOR;
                default: op = 5'($urandom);
            endcase
            a = 16'($urandom); b = 16'($urandom); use_acc = 1'($urandom);
            run1(op, a, b, use_acc, int'($urandom % 4), 1'b1, res, flg, lat, opa);
            expa  = use_acc ? acc_m : a;
            exp   = alu_ref(op, expa, b);
            acc_m = exp[15:0];
            cnt_m = cnt_m + 16'd1;
            $display("txn rand %0d op=%h a=%h b=%h use=%b res=%h flg=%b", i, op, a, b, use_acc, res, flg);
            n_cmp++;
            if (res !== exp[15:0] || flg !== exp[19:16] || opa !== expa || acc1 !== acc_m ||
                cnt1 !== cnt_m || lat !== 2) begin
                n_bad++;
                $display("FAIL rand_txn_%0d: res=%h flg=%b opa=%h acc=%h cnt=%0d lat=%0d required %h %b %h %h %0d 2",
                         i, res, flg, opa, acc1, cnt1, lat, exp[15:0], exp[19:16], expa, acc_m, cnt_m);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] res, opa;
        logic [3:0]  flg;
        int lat;
        u_d1.op_count_q = 16'hFFFF;
        #1;
        run1(OP_ADD, 16'd1, 16'd2, 1'b0, 0, 1'b0, res, flg, lat, opa);
        $display("txn wrap cnt=%h res=%h", cnt1, res);
        n_cmp++;
        if (cnt1 !== 16'h0000 || res !== 16'd3) begin
            n_bad++;
            $display("FAIL op_count_wrap: cnt=%h res=%h required 0000 0003", cnt1, res);
        end
    endtask

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0;
        c1_valid = 1'b0; c1_op = '0; c1_a = '0; c1_b = '0; c1_use = 1'b0; r1_ready = 1'b0;
        c3_valid = 1'b0; c3_op = '0; c3_a = '0; c3_b = '0; c3_use = 1'b0; r3_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst1_n = 1'b1; rst3_n = 1'b1;
        tick();
        test_and_direct();
        test_acc_chain();
        test_backpressure();
        test_settle();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
